// File: rtl/multicycle_adder_sub.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, LSB chunk first, carry held between cycles.
// Latency: start accepted at edge t -> done visible after edge t+NCHUNK; one op per NCHUNK+1 cycles.
// Backpressure: start is ignored while busy; start during the done cycle is accepted back-to-back.
module multicycle_adder_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] aop, bop, acc, acc_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] a_chk, b_chk, s_chk;
    logic             c_rip, c_msb, c_out;
    logic             last, accept;
    int               base;

    assign last = (cnt == CW'(NCHUNK - 1));

    // Bit-level ripple inside the chunk so the carry into the MSB is visible for overflow.
    always_comb begin
        base    = int'(cnt) * CHUNK;
        a_chk   = aop[base +: CHUNK];
        b_chk   = bop[base +: CHUNK];
        s_chk   = '0;
        c_rip   = carry;
        c_msb   = carry;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb = c_rip;
            s_chk[i] = a_chk[i] ^ b_chk[i] ^ c_rip;
            c_rip    = (a_chk[i] & b_chk[i]) | (a_chk[i] & c_rip) | (b_chk[i] & c_rip);
        end
        c_out   = c_rip;
        acc_nxt = acc;
        acc_nxt[base +: CHUNK] = s_chk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is folded into the operands at acceptance: A + ~B + ~Cin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aop      <= '0;
            bop      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            aop   <= A;
            bop   <= Sub ? ~B : B;
            carry <= Sub ? ~Cin : Cin;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= c_out;
            cnt   <= cnt + CW'(1);
            if (last) begin
                Sum      <= acc_nxt;
                Cout     <= c_out;
                Overflow <= c_msb ^ c_out;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_adder_sub.sv
// Directed + randomized bench for multicycle_adder_sub; three instances (CHUNK=4, 1, 16) share inputs.
module tb_multicycle_adder_sub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0, B = '0;
    logic        Cin = 1'b0, Sub = 1'b0;

    logic        busy4, done4, cout4, ovf4;
    logic [15:0] sum4;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_adder_sub #(.WIDTH(16), .CHUNK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4), .Overflow(ovf4));
    multicycle_adder_sub #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Overflow(ovf1));
    multicycle_adder_sub #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16), .Overflow(ovf16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed/unsigned integer arithmetic on the operands; returns {overflow, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        int          r;
        logic [16:0] u;
        logic        co, ov;
        if (!sub) begin
            r  = int'($signed(a)) + int'($signed(b)) + int'(cin);
            u  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
            co = u[16];
        end else begin
            r  = int'($signed(a)) - int'($signed(b)) - int'(cin);
            co = ({1'b0, a} >= ({1'b0, b} + {16'b0, cin}));
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, co, 16'(r)};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic [17:0] exp;
        int          lat, nbusy;
        exp = model(a, b, cin, sub);
        A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
        lat = 0; nbusy = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
            lat++;
            if (busy4) nbusy++;
        end while (!done4 && lat < 50);
        check("latency", 32'(lat), 32'd5);
        check("busy_cycles", 32'(nbusy), 32'd4);
        check("busy_during_done", 32'(busy4), 32'd0);
        check("sum", 32'(sum4), 32'(exp[15:0]));
        check("cout", 32'(cout4), 32'(exp[16]));
        check("overflow", 32'(ovf4), 32'(exp[17]));
        @(posedge clk); #1;
        check("done_single_pulse", 32'(done4), 32'd0);
        check("sum_hold", 32'(sum4), 32'(exp[15:0]));
    endtask

    initial begin
        logic [17:0] exp1;
        int          lat, ndone, l1, l4, l16;
        logic [15:0] s1, s4, s16, sd;

        // Reset state
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_sum", 32'(sum4), 32'd0);
        check("rst_cout", 32'(cout4), 32'd0);
        check("rst_ovf", 32'(ovf4), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0003, 1'b0, 1'b1);
        run_op(16'h0003, 16'h0005, 1'b1, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);

        // Start while busy is ignored
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        ndone = 0; sd = '0; lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 2) begin
                A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; Sub = 1'b1; start = 1'b1;
            end
            if (done4) begin ndone++; sd = sum4; lat = i; end
        end
        check("busy_start_ndone", 32'(ndone), 32'd1);
        check("busy_start_sum", 32'(sd), 32'h3333);
        check("busy_start_lat", 32'(lat), 32'd5);

        // Back-to-back start in the done cycle
        A = 16'h1234; B = 16'h0101; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        exp1 = model(16'h1234, 16'h0101, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end while (!done4 && lat < 50);
        check("b2b_first_sum", 32'(sum4), 32'(exp1[15:0]));
        A = 16'h0010; B = 16'h0020; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == 1) begin
                check("b2b_no_gap", 32'(busy4), 32'd1);
                check("b2b_sum_held", 32'(sum4), 32'(exp1[15:0]));
            end
        end while (!done4 && lat < 50);
        check("b2b_lat", 32'(lat), 32'd5);
        check("b2b_sum", 32'(sum4), 32'h0030);
        @(posedge clk); #1;

        // Asynchronous reset in RUN cycle 2
        A = 16'h7FFF; B = 16'h0001; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy4), 32'd0);
        check("arst_done", 32'(done4), 32'd0);
        check("arst_sum", 32'(sum4), 32'd0);
        check("arst_cout", 32'(cout4), 32'd0);
        check("arst_ovf", 32'(ovf4), 32'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done4) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done4) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0);

        // CHUNK = 1 / 4 / 16 side by side
        lat = 0;
        while ((busy1 || done1 || busy16 || done16 || busy4 || done4) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("chunk_idle", 32'(busy1 | busy16 | busy4), 32'd0);
        A = 16'h00FF; B = 16'h0001; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        l1 = 0; l4 = 0; l16 = 0; s1 = '0; s4 = '0; s16 = '0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done1)  begin l1 = i;  s1 = sum1;  end
            if (done4)  begin l4 = i;  s4 = sum4;  end
            if (done16) begin l16 = i; s16 = sum16; end
        end
        check("c1_lat", 32'(l1), 32'd17);
        check("c4_lat", 32'(l4), 32'd5);
        check("c16_lat", 32'(l16), 32'd2);
        check("c1_sum", 32'(s1), 32'h0100);
        check("c4_sum", 32'(s4), 32'h0100);
        check("c16_sum", 32'(s16), 32'h0100);
        check("c1_cout", 32'(cout1), 32'd0);
        check("c16_ovf", 32'(ovf16), 32'd0);

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
